writeback_stage: RTL and testbench

- Y86-64 pipeline M-to-W register and writeback control.
- Captures memory-stage results each cycle.
- Drives the W_* bus consumed by the decode stage, which uses it for register-file writes and forwarding.
- Holds the processor status FSM (run/stop) and an optional retired-instruction counter.

---
 rtl/y86_pkg.sv | 32 +++
 rtl/wb_status_fsm.sv | 33 +++
 rtl/writeback_stage.sv | 64 ++++++
 tb/tb_writeback_stage.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// y86_pkg: shared Y86-64 stat/icode/register constants, W register record and status FSM states
package y86_pkg;
  localparam int ICODE_W = 4;
  localparam int REG_W = 4;
  localparam int WORD_W = 64;
  localparam logic [1:0] SAOK = 2'd0;
  localparam logic [1:0] SHLT = 2'd1;
  localparam logic [1:0] SADR = 2'd2;
  localparam logic [1:0] SINS = 2'd3;
  localparam logic [ICODE_W-1:0] IHALT = 4'd0;
  localparam logic [ICODE_W-1:0] INOP = 4'd1;
  localparam logic [ICODE_W-1:0] IRRMOVQ = 4'd2;
  localparam logic [ICODE_W-1:0] IIRMOVQ = 4'd3;
  localparam logic [ICODE_W-1:0] IRMMOVQ = 4'd4;
  localparam logic [ICODE_W-1:0] IMRMOVQ = 4'd5;
  localparam logic [ICODE_W-1:0] IOPQ = 4'd6;
  localparam logic [ICODE_W-1:0] IJXX = 4'd7;
  localparam logic [ICODE_W-1:0] ICALL = 4'd8;
  localparam logic [ICODE_W-1:0] IRET = 4'd9;
  localparam logic [ICODE_W-1:0] IPUSHQ = 4'd10;
  localparam logic [ICODE_W-1:0] IPOPQ = 4'd11;
  localparam logic [REG_W-1:0] RNONE = 4'hF;
  typedef enum logic {RUN, STOP} wb_state_e;
  typedef struct packed {
    logic [1:0] stat;
    logic [ICODE_W-1:0] icode;
    logic [REG_W-1:0] dst_e;
    logic [REG_W-1:0] dst_m;
    logic [WORD_W-1:0] val_e;
    logic [WORD_W-1:0] val_m;
  } w_reg_t;
endpackage

// File: rtl/wb_status_fsm.sv
// wb_status_fsm: RUN/STOP processor status (in: clk, rst, w_stall_i, w_stat_i; out: proc_stat_o, halted_o)
module wb_status_fsm
  import y86_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       w_stall_i,
  input  logic [1:0] w_stat_i,
  output logic [1:0] proc_stat_o,
  output logic       halted_o
);
  wb_state_e state_q, state_d;
  logic [1:0] stat_q, stat_d;
  always_comb begin
    state_d = state_q;
    stat_d = stat_q;
    if (state_q == RUN && w_stat_i != SAOK && !w_stall_i) begin
      state_d = STOP;
      stat_d = w_stat_i;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      stat_q <= SAOK;
    end else begin
      state_q <= state_d;
      stat_q <= stat_d;
    end
  end
  assign proc_stat_o = stat_q;
  assign halted_o = state_q == STOP;
endmodule

// File: rtl/writeback_stage.sv
// writeback_stage: Y86-64 M-to-W register, W bus, write enables, status FSM, retire counter under WB_RETIRE_CNT_EN
module writeback_stage #(
  parameter int CNT_W = 32,
  parameter logic [3:0] RNONE = 4'hF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             W_stall,
  input  logic             W_bubble,
  input  logic [1:0]       m_stat,
  input  logic [3:0]       M_icode,
  input  logic [3:0]       M_dstE,
  input  logic [3:0]       M_dstM,
  input  logic [63:0]      M_valE,
  input  logic [63:0]      m_valM,
  output logic [1:0]       W_stat,
  output logic [3:0]       W_icode,
  output logic [3:0]       W_dstE,
  output logic [3:0]       W_dstM,
  output logic [63:0]      W_valE,
  output logic [63:0]      W_valM,
  output logic             wb_enE,
  output logic             wb_enM,
  output logic [1:0]       proc_stat,
  output logic             halted,
  output logic [CNT_W-1:0] retired_cnt
);
  import y86_pkg::*;
  localparam w_reg_t BUBBLE = '{stat: SAOK, icode: INOP, dst_e: RNONE, dst_m: RNONE, val_e: '0, val_m: '0};
  w_reg_t w_q, w_d, m_in;
  assign m_in = '{stat: m_stat, icode: M_icode, dst_e: M_dstE, dst_m: M_dstM, val_e: M_valE, val_m: m_valM};
  assign w_d = halted ? BUBBLE : W_stall ? w_q : W_bubble ? BUBBLE : m_in;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) w_q <= BUBBLE;
    else w_q <= w_d;
  end
  assign W_stat = w_q.stat;
  assign W_icode = w_q.icode;
  assign W_dstE = w_q.dst_e;
  assign W_dstM = w_q.dst_m;
  assign W_valE = w_q.val_e;
  assign W_valM = w_q.val_m;
  assign wb_enE = !halted && w_q.stat == SAOK && w_q.dst_e != RNONE;
  assign wb_enM = !halted && w_q.stat == SAOK && w_q.dst_m != RNONE;
  wb_status_fsm u_fsm (
    .clk         (clk),
    .rst         (rst),
    .w_stall_i   (W_stall),
    .w_stat_i    (w_q.stat),
    .proc_stat_o (proc_stat),
    .halted_o    (halted)
  );
`ifdef WB_RETIRE_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign cnt_d = (!halted && !W_stall && w_q.stat == SAOK && w_q.icode != INOP && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign retired_cnt = cnt_q;
`else
  assign retired_cnt = '0;
`endif
endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: randomized and directed check of writeback_stage against a behavioural model
module tb_writeback_stage;
  localparam int CW = 4;
`ifdef WB_RETIRE_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif
  logic clk = 0, rst = 1, W_stall = 0, W_bubble = 0;
  logic [1:0] m_stat = 0;
  logic [3:0] M_icode = 1, M_dstE = 15, M_dstM = 15;
  logic [63:0] M_valE = 0, m_valM = 0;
  logic [1:0] W_stat, proc_stat;
  logic [3:0] W_icode, W_dstE, W_dstM;
  logic [63:0] W_valE, W_valM;
  logic wb_enE, wb_enM, halted;
  logic [CW-1:0] retired_cnt;
  always #5 clk = ~clk;
  writeback_stage #(.CNT_W(CW), .RNONE(4'hF)) dut (
    .clk(clk), .rst(rst), .W_stall(W_stall), .W_bubble(W_bubble), .m_stat(m_stat),
    .M_icode(M_icode), .M_dstE(M_dstE), .M_dstM(M_dstM), .M_valE(M_valE), .m_valM(m_valM),
    .W_stat(W_stat), .W_icode(W_icode), .W_dstE(W_dstE), .W_dstM(W_dstM), .W_valE(W_valE),
    .W_valM(W_valM), .wb_enE(wb_enE), .wb_enM(wb_enM), .proc_stat(proc_stat), .halted(halted),
    .retired_cnt(retired_cnt)
  );
  typedef struct packed {
    logic [1:0] st;
    logic [3:0] ic, de, dm;
    logic [63:0] ve, vm;
  } rec_t;
  localparam rec_t NOP = '{st: 2'd0, ic: 4'd1, de: 4'd15, dm: 4'd15, ve: 64'd0, vm: 64'd0};
  rec_t mw;
  bit mstop, live, retire;
  logic [1:0] mps;
  int mcnt;
  int errs = 0, checks = 0;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mw = NOP; mstop = 0; mps = 0; mcnt = 0;
    end else if (mstop) begin
      mw = NOP;
    end else begin
      retire = !W_stall && mw.st == 0 && mw.ic != 1;
      if (CNT_ON && retire && mcnt < 15) mcnt++;
      if (!W_stall && mw.st != 0) begin
        mstop = 1; mps = mw.st;
      end
      if (!W_stall) mw = W_bubble ? NOP : '{st: m_stat, ic: M_icode, de: M_dstE, dm: M_dstM, ve: M_valE, vm: m_valM};
    end
  end
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  always @(negedge clk) begin
    if (live && !rst) begin
      chk("W_stat", W_stat, mw.st);
      chk("W_icode", W_icode, mw.ic);
      chk("W_dstE", W_dstE, mw.de);
      chk("W_dstM", W_dstM, mw.dm);
      chk("W_valE", W_valE, mw.ve);
      chk("W_valM", W_valM, mw.vm);
      chk("wb_enE", wb_enE, !mstop && mw.st == 0 && mw.de != 15);
      chk("wb_enM", wb_enM, !mstop && mw.st == 0 && mw.dm != 15);
      chk("proc_stat", proc_stat, mps);
      chk("halted", halted, mstop);
      chk("retired_cnt", retired_cnt, mcnt);
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_rst();
    rst = 1;
    #2;
    rst = 0;
  endtask
  task automatic setm(input logic [1:0] s, input logic [3:0] ic, input logic [3:0] de, input logic [3:0] dm, input logic [63:0] ve);
    m_stat = s; M_icode = ic; M_dstE = de; M_dstM = dm; M_valE = ve; m_valM = {$urandom, $urandom};
  endtask
  initial begin
    repeat (2) tick();
    rst = 0;
    live = 1;
    setm(0, 6, 3, 15, 64'h55);
    tick();
    chk("pre_rst_icode", W_icode, 6);
    chk("pre_rst_valE", W_valE, 64'h55);
    #1 rst = 1;
    #1;
    chk("arst_icode", W_icode, 1);
    chk("arst_dstE", W_dstE, 15);
    chk("arst_valE", W_valE, 0);
    chk("arst_cnt", retired_cnt, 0);
    #1 rst = 0;
    setm(0, 6, 2, 15, 64'h1234);
    tick();
    chk("norm_valE", W_valE, 64'h1234);
    chk("norm_enE", wb_enE, 1);
    chk("norm_enM", wb_enM, 0);
    setm(0, 6, 7, 15, 64'h77);
    tick();
    chk("norm_cnt", retired_cnt, CNT_ON ? 1 : 0);
    W_stall = 1;
    for (int i = 0; i < 3; i++) begin
      setm(0, 2, 9, 9, 64'h100 + i);
      tick();
    end
    chk("stall_valE", W_valE, 64'h77);
    chk("stall_cnt", retired_cnt, CNT_ON ? 1 : 0);
    W_bubble = 1;
    tick();
    chk("stall_wins_valE", W_valE, 64'h77);
    W_stall = 0;
    tick();
    chk("bubble_icode", W_icode, 1);
    chk("bubble_dstE", W_dstE, 15);
    chk("bubble_cnt", retired_cnt, CNT_ON ? 2 : 0);
    W_bubble = 0;
    setm(1, 0, 5, 15, 0);
    tick();
    chk("halt_Wstat", W_stat, 1);
    chk("halt_enE", wb_enE, 0);
    chk("halt_halted_early", halted, 0);
    setm(0, 6, 5, 15, 64'h99);
    tick();
    chk("halt_halted", halted, 1);
    chk("halt_proc_stat", proc_stat, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("halt_enE_after", wb_enE, 0);
    end
    do_rst();
    setm(2, 5, 15, 4, 0);
    tick();
    chk("fault_enM", wb_enM, 0);
    setm(0, 1, 15, 15, 0);
    tick();
    chk("fault_proc_stat", proc_stat, 2);
    do_rst();
    #1;
    chk("fault_rst_proc_stat", proc_stat, 0);
    chk("fault_rst_halted", halted, 0);
    setm(0, 11, 4, 4, 64'h10);
    tick();
    chk("popq_enE", wb_enE, 1);
    chk("popq_enM", wb_enM, 1);
    do_rst();
    for (int i = 0; i < 20; i++) begin
      setm(0, 6, 1, 15, 64'(i));
      tick();
    end
    setm(0, 1, 15, 15, 0);
    tick();
    chk("sat_cnt", retired_cnt, CNT_ON ? 15 : 0);
    for (int i = 0; i < 800; i++) begin
      if (mstop && $urandom_range(0, 5) == 0) do_rst();
      W_stall = $urandom_range(0, 4) == 0;
      W_bubble = $urandom_range(0, 4) == 0;
      setm($urandom_range(0, 24) == 0 ? 2'($urandom_range(1, 3)) : 2'd0, 4'($urandom_range(0, 11)),
           $urandom_range(0, 2) == 0 ? 4'hF : 4'($urandom), $urandom_range(0, 2) == 0 ? 4'hF : 4'($urandom),
           {$urandom, $urandom});
      tick();
    end
    live = 0;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
